// File: rtl/dds_pkg.sv
// Shared encodings and helpers for the DDS front-panel key controller.
package dds_pkg;

    typedef enum logic [1:0] {
        FIELD_FREQ = 2'd0,
        FIELD_WAVE = 2'd1,
        FIELD_AMP  = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_HOLD   = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_e;

    localparam int STEP_SHIFT = 4;

    function automatic field_e next_field(input field_e f);
        case (f)
            FIELD_FREQ: return FIELD_WAVE;
            FIELD_WAVE: return FIELD_AMP;
            default:    return FIELD_FREQ;
        endcase
    endfunction

endpackage

// File: rtl/dds_key_ctrl_if.sv
// Key-pulse inputs and configuration outputs of the DDS front-panel controller.
interface dds_key_ctrl_if #(
    parameter int FW_W = 32
);
    logic            mode_pressed;
    logic            up_pressed;
    logic            up_released;
    logic            dn_pressed;
    logic            dn_released;
    logic            step_pressed;
    logic [FW_W-1:0] freq_word;
    logic [1:0]      wave_sel;
    logic [1:0]      amp_sel;
    logic [1:0]      edit_field;
    logic [1:0]      step_idx;
    logic            cfg_update;

    modport master (
        output mode_pressed, up_pressed, up_released, dn_pressed, dn_released, step_pressed,
        input  freq_word, wave_sel, amp_sel, edit_field, step_idx, cfg_update
    );

    modport slave (
        input  mode_pressed, up_pressed, up_released, dn_pressed, dn_released, step_pressed,
        output freq_word, wave_sel, amp_sel, edit_field, step_idx, cfg_update
    );
endinterface

// File: rtl/dds_key_ctrl_key_repeat.sv
// Press-and-hold auto-repeat engine for one key: an immediate step on press,
// then one step after the hold delay and every repeat period until release.
module key_repeat
    import dds_pkg::*;
#(
    parameter int HOLD_CYCLES   = 500_000,
    parameter int REPEAT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed,
    input  logic released,
    input  logic cancel,
    output logic tick,
    output logic active
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    key_state_e       state;
    logic [CNT_W-1:0] cnt;

    // The tick is decoded from the current state so the owner's registers move
    // on the same edge that samples the key pulse.
    always_comb begin
        tick = 1'b0;
        case (state)
            KEY_IDLE:   tick = pressed && !cancel;
            KEY_HOLD:   tick = !released && !cancel && (cnt == HOLD_LAST);
            KEY_REPEAT: tick = !released && !cancel && (cnt == REPEAT_LAST);
            default:    tick = 1'b0;
        endcase
    end

    assign active = (state != KEY_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KEY_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                KEY_IDLE: begin
                    if (pressed && !cancel) begin
                        state <= KEY_HOLD;
                        cnt   <= '0;
                    end
                end
                KEY_HOLD: begin
                    if (released || cancel) begin
                        state <= KEY_IDLE;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= KEY_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                KEY_REPEAT: begin
                    if (released || cancel) begin
                        state <= KEY_IDLE;
                        cnt   <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= KEY_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dds_key_ctrl.sv
// DDS front-panel controller: turns key pulses into frequency word, waveform
// and amplitude settings with saturating steps and an update strobe.
module dds_key_ctrl
    import dds_pkg::*;
#(
    parameter int              FW_W          = 32,
    parameter logic [FW_W-1:0] FW_MIN        = 32'd1,
    parameter logic [FW_W-1:0] FW_MAX        = 32'h7FFF_FFFF,
    parameter logic [FW_W-1:0] FW_DEFAULT    = 32'd4295,
    parameter int              HOLD_CYCLES   = 500_000,
    parameter int              REPEAT_CYCLES = 100_000
) (
    input logic           clk,
    input logic           rst_n,
    dds_key_ctrl_if.slave bus
);
    localparam logic [FW_W:0] ONE_W = {{FW_W{1'b0}}, 1'b1};
    localparam logic [FW_W:0] MIN_W = {1'b0, FW_MIN};
    localparam logic [FW_W:0] MAX_W = {1'b0, FW_MAX};

    logic [FW_W-1:0] freq_word;
    logic [1:0]      wave_sel;
    logic [1:0]      amp_sel;
    field_e          edit_field;
    logic [1:0]      step_idx;
    logic            cfg_update;

    logic up_tick, dn_tick, up_active, dn_active;

    // Each key is cancelled by the other key or MODE, and cannot start while the other is held.
    key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .pressed  (bus.up_pressed),
        .released (bus.up_released),
        .cancel   (bus.dn_pressed | bus.mode_pressed | dn_active),
        .tick     (up_tick),
        .active   (up_active)
    );

    key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
        .clk      (clk),
        .rst_n    (rst_n),
        .pressed  (bus.dn_pressed),
        .released (bus.dn_released),
        .cancel   (bus.up_pressed | bus.mode_pressed | up_active),
        .tick     (dn_tick),
        .active   (dn_active)
    );

    logic [FW_W:0]   fw_step, fw_sum, fw_diff;
    logic [FW_W-1:0] fw_next;
    logic [1:0]      wave_next, amp_next;

    assign fw_step = ONE_W << (int'(step_idx) * STEP_SHIFT);
    assign fw_sum  = {1'b0, freq_word} + fw_step;
    assign fw_diff = {1'b0, freq_word} - fw_step;

    // One extra bit lets both directions detect overflow/borrow before clamping.
    always_comb begin
        fw_next   = freq_word;
        wave_next = wave_sel;
        amp_next  = amp_sel;
        if (up_tick) begin
            fw_next   = (fw_sum > MAX_W) ? FW_MAX : fw_sum[FW_W-1:0];
            wave_next = wave_sel + 2'd1;
            amp_next  = (amp_sel == 2'd3) ? amp_sel : amp_sel + 2'd1;
        end else if (dn_tick) begin
            fw_next   = (fw_diff[FW_W] || (fw_diff < MIN_W)) ? FW_MIN : fw_diff[FW_W-1:0];
            wave_next = wave_sel - 2'd1;
            amp_next  = (amp_sel == 2'd0) ? amp_sel : amp_sel - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_word  <= FW_DEFAULT;
            wave_sel   <= WAVE_SINE;
            amp_sel    <= 2'd0;
            edit_field <= FIELD_FREQ;
            step_idx   <= 2'd0;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            if (bus.mode_pressed) edit_field <= next_field(edit_field);
            if (bus.step_pressed) step_idx <= step_idx + 2'd1;
            case (edit_field)
                FIELD_FREQ: if (fw_next != freq_word) begin
                    freq_word  <= fw_next;
                    cfg_update <= 1'b1;
                end
                FIELD_WAVE: if (wave_next != wave_sel) begin
                    wave_sel   <= wave_next;
                    cfg_update <= 1'b1;
                end
                FIELD_AMP: if (amp_next != amp_sel) begin
                    amp_sel    <= amp_next;
                    cfg_update <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.freq_word  = freq_word;
    assign bus.wave_sel   = wave_sel;
    assign bus.amp_sel    = amp_sel;
    assign bus.edit_field = edit_field;
    assign bus.step_idx   = step_idx;
    assign bus.cfg_update = cfg_update;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Scoreboard bench for dds_key_ctrl: a time-since-press reference model feeds
// expected outputs into a queue that a monitor drains once per clock.
module tb_dds_key_ctrl;
    localparam int  HOLD     = 20;
    localparam int  REPEAT   = 5;
    localparam longint FMIN  = 1;
    localparam longint FMAX  = 64'h7FFF_FFFF;
    localparam longint FDEF  = 4295;

    typedef struct packed {
        logic [31:0] fw;
        logic [1:0]  ws;
        logic [1:0]  as;
        logic [1:0]  ef;
        logic [1:0]  si;
        logic        upd;
    } exp_t;

    logic clk;
    logic rst_n;
    dds_key_ctrl_if bus ();

    dds_key_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    exp_t exp_q[$];

    longint m_fw;
    int m_wave, m_amp, m_field, m_step, m_held, m_t0, m_cyc;

    task automatic modelReset();
        m_fw = FDEF; m_wave = 0; m_amp = 0; m_field = 0; m_step = 0;
        m_held = 0; m_t0 = 0; m_cyc = 0;
    endtask

    function automatic exp_t resetExp();
        exp_t e;
        e.fw = 32'(FDEF); e.ws = 2'd0; e.as = 2'd0; e.ef = 2'd0; e.si = 2'd0; e.upd = 1'b0;
        return e;
    endfunction

    // Reference: a held key steps at press, at HOLD cycles later, then every REPEAT cycles.
    task automatic modelStep(input bit m, u, ur, d, dr, s, output exp_t e);
        int dir, el, na;
        longint stp, nf;
        bit upd;
        dir = 0; upd = 1'b0;
        m_cyc++;
        if (m_held == 0) begin
            if (u && !d && !m) begin m_held = 1; m_t0 = m_cyc; dir = 1; end
            else if (d && !u && !m) begin m_held = -1; m_t0 = m_cyc; dir = -1; end
        end else if ((m_held == 1 && (ur || d)) || (m_held == -1 && (dr || u)) || m) begin
            m_held = 0;
        end else begin
            el = m_cyc - m_t0;
            if (el >= HOLD && ((el - HOLD) % REPEAT) == 0) dir = m_held;
        end
        if (dir != 0) begin
            case (m_field)
                0: begin
                    stp = longint'(1) << (4 * m_step);
                    nf  = m_fw + dir * stp;
                    if (nf > FMAX) nf = FMAX;
                    if (nf < FMIN) nf = FMIN;
                    upd  = (nf != m_fw);
                    m_fw = nf;
                end
                1: begin m_wave = (m_wave + dir + 4) % 4; upd = 1'b1; end
                default: begin
                    na = m_amp + dir;
                    if (na < 0) na = 0;
                    if (na > 3) na = 3;
                    upd   = (na != m_amp);
                    m_amp = na;
                end
            endcase
        end
        if (m) m_field = (m_field + 1) % 3;
        if (s) m_step = (m_step + 1) % 4;
        e.fw = 32'(m_fw); e.ws = 2'(m_wave); e.as = 2'(m_amp);
        e.ef = 2'(m_field); e.si = 2'(m_step); e.upd = upd;
    endtask

    task automatic checkOutput(input string name, input exp_t want);
        exp_t act;
        act.fw = bus.freq_word; act.ws = bus.wave_sel; act.as = bus.amp_sel;
        act.ef = bus.edit_field; act.si = bus.step_idx; act.upd = bus.cfg_update;
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got fw=%0d wave=%0d amp=%0d field=%0d step=%0d upd=%0b, want fw=%0d wave=%0d amp=%0d field=%0d step=%0d upd=%0b",
                     name, $time, act.fw, act.ws, act.as, act.ef, act.si, act.upd,
                     want.fw, want.ws, want.as, want.ef, want.si, want.upd);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // One clock of stimulus: drive pulses for one edge, queue the model's answer.
    task automatic applyStimulus(input bit m, u, ur, d, dr, s);
        exp_t e;
        @(negedge clk);
        bus.mode_pressed = m; bus.up_pressed = u; bus.up_released = ur;
        bus.dn_pressed = d; bus.dn_released = dr; bus.step_pressed = s;
        modelStep(m, u, ur, d, dr, s, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.mode_pressed = 0; bus.up_pressed = 0; bus.up_released = 0;
        bus.dn_pressed = 0; bus.dn_released = 0; bus.step_pressed = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("scoreboard", e);
        end
    end

    initial begin
        bus.mode_pressed = 0; bus.up_pressed = 0; bus.up_released = 0;
        bus.dn_pressed = 0; bus.dn_released = 0; bus.step_pressed = 0;
        rst_n = 1'b1;
        modelReset();
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_assert", resetExp());
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("reset_exit", resetExp());

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkValue("first_up_fw", bus.freq_word, 4296);
        checkValue("first_up_strobe", 32'(bus.cfg_update), 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkValue("down_4096_fw", bus.freq_word, 200);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkValue("clamp_min_fw", bus.freq_word, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkValue("at_min_no_strobe", 32'(bus.cfg_update), 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(39);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idle(10);
        checkValue("hold_repeat_fw", bus.freq_word, 6);

        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            applyStimulus(0, 0, 1, 0, 0, 0);
        end
        checkValue("wave_after_5_up", 32'(bus.wave_sel), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkValue("amp_floor", 32'(bus.amp_sel), 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        idle(25);
        checkValue("both_keys_ignored", bus.freq_word, 6);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(5);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(30);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkValue("cancelled_hold_fw", bus.freq_word, 7);

        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(27);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_mid_repeat", resetExp());
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("reset_exit_2", resetExp());
        idle(30);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 6, $urandom_range(99) < 4,
                          $urandom_range(99) < 6, $urandom_range(99) < 4, $urandom_range(99) < 4);
        end
        idle(2);
        repeat (2) @(posedge clk);
        #3;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
